target_scheduler: RTL and testbench
===================================

Name: target_scheduler

Overview:
- Sequences the GAME phase of the aim-trainer.
- Spawns NUM_TARGETS square targets one after another at pseudo-random positions.
- Decides hit or miss on each mouse click or timeout, and keeps hit/miss/score counters.
- Drives the position and visibility inputs of the target rect-draw stage, and reports round completion to the top-level game state machine.

Parameters:
- H_RES, 1024, visible width in pixels.
- V_RES, 768, visible height in pixels.
- TARGET_SIZE, 64, target side length in pixels.
- TARGET_TIMEOUT, 50_000_000, pclk cycles a target stays up before it counts as a miss.
- NUM_TARGETS, 20, targets per round (1..255).

Ports:
- pclk  in  1  pixel clock; all logic on its rising edge.
- rst_d  in  1  synchronous, active-high reset.
- game_active  in  1  high while the top FSM is in GAME.
- mouse_left  in  1  left-button level, already synchronous to pclk.
- mouse_xpos  in  12  cursor x.
- mouse_ypos  in  12  cursor y.
- target_xpos  out  11  target left edge.
- target_ypos  out  11  target top edge.
- target_visible  out  1  draw-enable for the target rect.
- hits  out  8  hit count.
- misses  out  8  miss count.
- round_done  out  1  high once all targets are resolved.

Behaviour:
- Reset (rst_d=1 at a pclk edge) forces:
  - state IDLE;
  - target_xpos=0, target_ypos=0, target_visible=0;
  - hits=0, misses=0, round_done=0;
  - timeout counter=0, target counter=0, click-edge register=0;
  - LFSR=16'hACE1.
- All outputs are registered.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle when not in reset.
  - Never reaches all-zero.
- Position generation, SPAWN state only:
  - rx = lfsr[9:0]; x = (rx >= H_RES-TARGET_SIZE) ? rx-(H_RES-TARGET_SIZE) : rx.
  - ry = lfsr[15:6]; y = (ry >= V_RES-TARGET_SIZE) ? ry-(V_RES-TARGET_SIZE) : ry.
  - With the defaults one conditional subtraction always suffices.
  - Targets therefore lie fully on screen.
- Click detection:
  - click = mouse_left & ~mouse_left_q (one-cycle rising edge); a held button counts once.
- Hit test, combinational on registered target:
  - target_xpos <= mouse_xpos <= target_xpos+TARGET_SIZE-1;
  - target_ypos <= mouse_ypos <= target_ypos+TARGET_SIZE-1;
  - compare at 12 bits, with zero-extended target coordinates.
- States:
  - IDLE: target_visible=0; hits, misses and round_done hold. If game_active=1 → SPAWN, clearing hits, misses, target counter and round_done.
  - SPAWN, 1 cycle: latch x/y into target_xpos/ypos, clear timeout counter → SHOW.
  - SHOW: target_visible=1 from the first SHOW cycle; timeout counter increments each cycle.
    - click & hit → HIT.
    - Else timeout counter == TARGET_TIMEOUT-1 → MISS.
    - A click outside the target is ignored; the target stays up.
  - HIT, 1 cycle: target_visible=0; hits += 1, saturating at 255; target counter += 1.
    - Go to DONE if the new count == NUM_TARGETS, else SPAWN.
  - MISS, 1 cycle: as HIT, but misses += 1.
  - DONE: round_done=1, target_visible=0; counters hold. game_active=0 → IDLE (round_done stays 1 until the next game start).
- Latency:
  - game_active rise at edge N → SPAWN at N+1 → target_visible=1 at N+2.
  - A hit click at edge M → target_visible=0 at M+1, hits updated at M+2.
- Simultaneous click-hit and last timeout cycle: HIT wins.
- Abort: game_active=0 in SPAWN, SHOW, HIT or MISS → IDLE next cycle.
  - target_visible drops; counters freeze at their current values.
  - A pending HIT/MISS increment still commits that cycle.
- rst_d asserted mid-round: full reset next edge, regardless of state.
- Invariant: hits + misses == targets resolved ≤ NUM_TARGETS.

Decomposition:
- Shared package holds the state encoding localparams: IDLE=3'd0, SPAWN=3'd1, SHOW=3'd2, HIT=3'd3, MISS=3'd4, DONE=3'd5.
- It also holds H_RES/V_RES and TARGET_SIZE, also used by the draw stage.
- One sub-module: lfsr16 (pclk, rst_d, output [15:0] value), reusable elsewhere.
- FSM, counters, hit test and position mapping stay in target_scheduler.

Test Plan (bench overrides TARGET_TIMEOUT=16, NUM_TARGETS=4):
- Reset, then game_active=1 → target_visible=1 exactly 2 cycles after the game_active rise; target_xpos ≤ 960, target_ypos ≤ 704; hits=misses=0.
- In SHOW, set mouse to (target_xpos+63, target_ypos+63) and pulse mouse_left → hits=1 two cycles later; a new target appears.
- Click at (target_xpos+64, target_ypos) → ignored; after 16 SHOW cycles misses=1.
- Hold mouse_left high across two targets → only one hit counted.
- Four resolutions (e.g. 3 hits, 1 miss) → round_done=1, hits=3, misses=1.
- Then game_active=0 then 1 → counters cleared and round_done=0 on the SPAWN entry.
- Hit click on the 16th SHOW cycle → hits increments, misses unchanged.
- game_active=0 during SHOW → target_visible=0 next cycle; counters frozen.
- rst_d=1 mid-SHOW → all outputs zero next edge.

Source files
------------

// File: rtl/target_scheduler_pkg.sv
// Shared definitions for the aim-trainer GAME phase: screen geometry used by
// both the scheduler and the target rect-draw stage, the scheduler state
// encoding, and the position wrap helper that keeps targets fully on screen.
package target_scheduler_pkg;

   localparam int H_RES       = 1024;
   localparam int V_RES       = 768;
   localparam int TARGET_SIZE = 64;

   typedef logic [10:0] target_coord_t;
   typedef logic [11:0] mouse_coord_t;

   // Largest legal left/top edge plus one; anything at or above folds back.
   localparam target_coord_t X_LIM = target_coord_t'(H_RES - TARGET_SIZE);
   localparam target_coord_t Y_LIM = target_coord_t'(V_RES - TARGET_SIZE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SPAWN = 3'd1,
      SHOW  = 3'd2,
      HIT   = 3'd3,
      MISS  = 3'd4,
      DONE  = 3'd5
   } state_t;

   // One conditional subtraction is enough because a 10-bit random value
   // never exceeds twice the limit for the default geometry.
   function automatic target_coord_t wrap_coord(input logic [9:0] r,
                                                input target_coord_t lim);
      target_coord_t r11;
      r11 = {1'b0, r};
      return (r11 >= lim) ? target_coord_t'(r11 - lim) : r11;
   endfunction

endpackage

// File: rtl/target_scheduler_if.sv
// Bundle between the GAME-phase scheduler and its surroundings.
//   game_active, mouse_left, mouse_xpos, mouse_ypos : into the scheduler
//   target_xpos, target_ypos, target_visible        : to the rect-draw stage
//   hits, misses, round_done                        : to the top game FSM
// slave = scheduler side, master = driver side (top level or bench).
interface target_scheduler_if;
   import target_scheduler_pkg::*;

   logic          game_active;
   logic          mouse_left;
   mouse_coord_t  mouse_xpos;
   mouse_coord_t  mouse_ypos;
   target_coord_t target_xpos;
   target_coord_t target_ypos;
   logic          target_visible;
   logic [7:0]    hits;
   logic [7:0]    misses;
   logic          round_done;

   modport master (
      output game_active, mouse_left, mouse_xpos, mouse_ypos,
      input  target_xpos, target_ypos, target_visible, hits, misses, round_done
   );

   modport slave (
      input  game_active, mouse_left, mouse_xpos, mouse_ypos,
      output target_xpos, target_ypos, target_visible, hits, misses, round_done
   );

endinterface

// File: rtl/target_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded with 16'hACE1.
//   pclk  : clock, rising edge
//   rst_d : synchronous active-high reset, reloads the seed
//   value : current register contents, advances every non-reset cycle
// The seed is non-zero and the polynomial is maximal length, so the
// all-zero lock-up state is never reached.
module lfsr16 (
   input  logic        pclk,
   input  logic        rst_d,
   output logic [15:0] value
);

   always_ff @(posedge pclk) begin
      if (rst_d)
         value <= 16'hACE1;
      else
         value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
   end

endmodule

// File: rtl/target_scheduler.sv
// GAME-phase target scheduler: spawns NUM_TARGETS targets at pseudo-random
// positions, resolves each as hit (click inside) or miss (timeout), counts
// hits/misses and flags round completion.
//   pclk  : clock, rising edge
//   rst_d : synchronous active-high reset
//   bus   : target_scheduler_if.slave (game/mouse in; target/score out)
//
// state | meaning
// IDLE  | waiting for game_active; scores and round_done hold
// SPAWN | latch a new random position, clear the timeout counter
// SHOW  | target visible; wait for a hit click or timeout
// HIT   | count a hit, advance target counter
// MISS  | count a miss, advance target counter
// DONE  | all targets resolved; round_done high until next game start
module target_scheduler
   import target_scheduler_pkg::*;
#(
   parameter int TARGET_TIMEOUT = 50_000_000,
   parameter int NUM_TARGETS    = 20
) (
   input  logic                pclk,
   input  logic                rst_d,
   target_scheduler_if.slave   bus
);

   localparam int TO_W = (TARGET_TIMEOUT > 1) ? $clog2(TARGET_TIMEOUT) : 1;

   state_t        state_q, state_d;
   logic [15:0]   lfsr;
   logic          mouse_left_q;
   logic          click, hit, timeout_tc, last_target;
   logic [TO_W-1:0] to_cnt;
   logic [7:0]    tgt_cnt, tgt_cnt_inc;
   target_coord_t x_q, y_q;
   logic          vis_q, done_q;
   logic [7:0]    hits_q, misses_q;

   lfsr16 u_lfsr (
      .pclk  (pclk),
      .rst_d (rst_d),
      .value (lfsr)
   );

   assign click       = bus.mouse_left & ~mouse_left_q;
   assign hit         = (bus.mouse_xpos >= {1'b0, x_q}) &&
                        (bus.mouse_xpos <= {1'b0, x_q} + 12'(TARGET_SIZE - 1)) &&
                        (bus.mouse_ypos >= {1'b0, y_q}) &&
                        (bus.mouse_ypos <= {1'b0, y_q} + 12'(TARGET_SIZE - 1));
   assign timeout_tc  = (to_cnt == TO_W'(TARGET_TIMEOUT - 1));
   assign tgt_cnt_inc = tgt_cnt + 8'd1;
   assign last_target = (tgt_cnt_inc == 8'(NUM_TARGETS));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.game_active) state_d = SPAWN;
         SPAWN:     state_d = bus.game_active ? SHOW : IDLE;
         SHOW: begin
            if (!bus.game_active)  state_d = IDLE;
            else if (click && hit) state_d = HIT;   // hit beats a same-cycle timeout
            else if (timeout_tc)   state_d = MISS;
         end
         HIT, MISS: begin
            if (!bus.game_active) state_d = IDLE;
            else if (last_target) state_d = DONE;
            else                  state_d = SPAWN;
         end
         DONE:      if (!bus.game_active) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst_d) begin
         state_q      <= IDLE;
         mouse_left_q <= 1'b0;
         to_cnt       <= '0;
         tgt_cnt      <= 8'd0;
         x_q          <= '0;
         y_q          <= '0;
         vis_q        <= 1'b0;
         hits_q       <= 8'd0;
         misses_q     <= 8'd0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mouse_left_q <= bus.mouse_left;
         // Registered from next state so visibility tracks SHOW exactly.
         vis_q        <= (state_d == SHOW);
         case (state_q)
            IDLE: if (bus.game_active) begin
               hits_q   <= 8'd0;
               misses_q <= 8'd0;
               tgt_cnt  <= 8'd0;
               done_q   <= 1'b0;
            end
            SPAWN: begin
               x_q    <= wrap_coord(lfsr[9:0], X_LIM);
               y_q    <= wrap_coord(lfsr[15:6], Y_LIM);
               to_cnt <= '0;
            end
            SHOW: to_cnt <= to_cnt + 1'b1;
            // Increments commit even when the round is being aborted.
            HIT: begin
               if (hits_q != 8'hFF) hits_q <= hits_q + 8'd1;
               tgt_cnt <= tgt_cnt_inc;
            end
            MISS: begin
               if (misses_q != 8'hFF) misses_q <= misses_q + 8'd1;
               tgt_cnt <= tgt_cnt_inc;
            end
            default: ;
         endcase
         if (state_d == DONE) done_q <= 1'b1;
      end
   end

   assign bus.target_xpos    = x_q;
   assign bus.target_ypos    = y_q;
   assign bus.target_visible = vis_q;
   assign bus.hits           = hits_q;
   assign bus.misses         = misses_q;
   assign bus.round_done     = done_q;

endmodule

// File: tb/tb_target_scheduler.sv
// Self-checking bench for target_scheduler with TARGET_TIMEOUT=16,
// NUM_TARGETS=4: hand-written sequences for the multi-cycle corners plus a
// table of hit-test boundary clicks.
module tb_target_scheduler;

   localparam int TO = 16;
   localparam int NT = 4;

   logic pclk  = 1'b0;
   logic rst_d = 1'b1;
   always #5 pclk = ~pclk;

   target_scheduler_if bus ();

   target_scheduler #(.TARGET_TIMEOUT(TO), .NUM_TARGETS(NT)) dut (
      .pclk  (pclk),
      .rst_d (rst_d),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference LFSR; lfsr_prev is the value the design saw before the last edge.
   logic [15:0] lfsr_m    = 16'hACE1;
   logic [15:0] lfsr_prev = 16'hACE1;
   always @(posedge pclk) begin
      lfsr_prev = lfsr_m;
      if (rst_d) lfsr_m = 16'hACE1;
      else       lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   logic [10:0] cur_x, cur_y;

   typedef struct {
      int   dx;
      int   dy;
      logic hit;
   } vec_t;
   vec_t vecs[10];

   function automatic logic [10:0] exp_x(input logic [15:0] l);
      logic [10:0] r;
      r = {1'b0, l[9:0]};
      return (r >= 11'd960) ? r - 11'd960 : r;
   endfunction

   function automatic logic [10:0] exp_y(input logic [15:0] l);
      logic [10:0] r;
      r = {1'b0, l[15:6]};
      return (r >= 11'd704) ? r - 11'd704 : r;
   endfunction

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_vis(input logic v, input int max_cyc);
      int n;
      n = 0;
      while (bus.target_visible !== v && n < max_cyc) begin
         tick();
         n++;
      end
      if (bus.target_visible !== v) check("wait_visible", bus.target_visible, v);
   endtask

   task automatic note_target(input string tag);
      cur_x = exp_x(lfsr_prev);
      cur_y = exp_y(lfsr_prev);
      check({tag, "_xpos"}, bus.target_xpos, cur_x);
      check({tag, "_ypos"}, bus.target_ypos, cur_y);
   endtask

   task automatic aim(input int dx, input int dy);
      bus.mouse_xpos = 12'(int'(cur_x) + dx);
      bus.mouse_ypos = 12'(int'(cur_y) + dy);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vis"},    bus.target_visible, 0);
      check({tag, "_xpos"},   bus.target_xpos, 0);
      check({tag, "_ypos"},   bus.target_ypos, 0);
      check({tag, "_hits"},   bus.hits, 0);
      check({tag, "_misses"}, bus.misses, 0);
      check({tag, "_done"},   bus.round_done, 0);
   endtask

   task automatic start_round(input string tag);
      bus.mouse_left  = 1'b0;
      bus.game_active = 1'b0;
      tick();
      tick();
      bus.game_active = 1'b1;
      tick();
      tick();
      check({tag, "_vis"}, bus.target_visible, 1);
      note_target(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0,   0,  1'b1};
      vecs[1] = '{63,  63, 1'b1};
      vecs[2] = '{64,  0,  1'b0};
      vecs[3] = '{0,   64, 1'b0};
      vecs[4] = '{-1,  0,  1'b0};
      vecs[5] = '{0,   -1, 1'b0};
      vecs[6] = '{63,  0,  1'b1};
      vecs[7] = '{0,   63, 1'b1};
      vecs[8] = '{32,  32, 1'b1};
      vecs[9] = '{64,  64, 1'b0};

      bus.game_active = 1'b0;
      bus.mouse_left  = 1'b0;
      bus.mouse_xpos  = '0;
      bus.mouse_ypos  = '0;
      rst_d = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      rst_d = 1'b0;
      tick();

      // Start latency: SPAWN after one edge, visible after two.
      bus.game_active = 1'b1;
      tick();
      check("start_vis_edge1", bus.target_visible, 0);
      tick();
      check("start_vis_edge2", bus.target_visible, 1);
      note_target("t1");
      check("t1_x_bound", (bus.target_xpos <= 11'd960), 1);
      check("t1_y_bound", (bus.target_ypos <= 11'd704), 1);
      check("start_hits", bus.hits, 0);
      check("start_misses", bus.misses, 0);

      // Target 1: hit at the bottom-right pixel.
      aim(63, 63);
      bus.mouse_left = 1'b1;
      tick();
      check("t1_vis_drop", bus.target_visible, 0);
      bus.mouse_left = 1'b0;
      tick();
      check("t1_hits", bus.hits, 1);
      tick();
      check("t2_vis", bus.target_visible, 1);
      note_target("t2");

      // Target 2: click just right of the target, then time out.
      aim(64, 0);
      bus.mouse_left = 1'b1;
      tick();
      check("t2_outside_ignored", bus.target_visible, 1);
      bus.mouse_left = 1'b0;
      repeat (14) tick();
      check("t2_vis_before_to", bus.target_visible, 1);
      check("t2_misses_before_to", bus.misses, 0);
      tick();
      check("t2_vis_at_to", bus.target_visible, 0);
      tick();
      check("t2_misses", bus.misses, 1);
      check("t2_hits", bus.hits, 1);
      wait_vis(1'b1, 4);
      note_target("t3");

      // Target 3 hit with the button held through target 4.
      aim(0, 0);
      bus.mouse_left = 1'b1;
      tick();
      check("t3_vis_drop", bus.target_visible, 0);
      tick();
      check("t3_hits", bus.hits, 2);
      tick();
      check("t4_vis", bus.target_visible, 1);
      note_target("t4");
      aim(10, 10);
      repeat (15) tick();
      check("held_no_hit", bus.hits, 2);
      check("held_vis", bus.target_visible, 1);
      tick();
      tick();
      check("round_done", bus.round_done, 1);
      check("round_hits", bus.hits, 2);
      check("round_misses", bus.misses, 2);
      check("round_vis", bus.target_visible, 0);
      bus.mouse_left = 1'b0;
      tick();
      tick();
      check("done_hold", bus.round_done, 1);

      // Restart: round_done survives IDLE, clears on SPAWN entry.
      bus.game_active = 1'b0;
      tick();
      check("idle_done_hold", bus.round_done, 1);
      check("idle_hits_hold", bus.hits, 2);
      bus.game_active = 1'b1;
      tick();
      check("restart_hits", bus.hits, 0);
      check("restart_misses", bus.misses, 0);
      check("restart_done", bus.round_done, 0);
      tick();
      check("restart_vis", bus.target_visible, 1);
      note_target("r1");

      // Hit click sampled on the same edge as the timeout.
      aim(5, 5);
      repeat (15) tick();
      check("late_vis", bus.target_visible, 1);
      bus.mouse_left = 1'b1;
      tick();
      check("late_vis_drop", bus.target_visible, 0);
      bus.mouse_left = 1'b0;
      tick();
      check("late_hits", bus.hits, 1);
      check("late_misses", bus.misses, 0);

      // Abort in SHOW.
      wait_vis(1'b1, 4);
      note_target("r2");
      tick();
      tick();
      bus.game_active = 1'b0;
      tick();
      check("abort_vis", bus.target_visible, 0);
      check("abort_hits", bus.hits, 1);
      check("abort_misses", bus.misses, 0);
      repeat (20) tick();
      check("abort_hits_frozen", bus.hits, 1);
      check("abort_misses_frozen", bus.misses, 0);
      check("abort_done", bus.round_done, 0);

      // Hit-test boundary table, one fresh round per vector.
      for (int i = 0; i < 10; i++) begin
         start_round($sformatf("tbl%0d", i));
         aim(vecs[i].dx, vecs[i].dy);
         bus.mouse_left = 1'b1;
         tick();
         check($sformatf("tbl%0d_vis", i), bus.target_visible, !vecs[i].hit);
         bus.mouse_left = 1'b0;
         tick();
         check($sformatf("tbl%0d_hits", i), bus.hits, vecs[i].hit);
      end

      // Reset in the middle of SHOW.
      start_round("rst");
      aim(0, 0);
      bus.mouse_left = 1'b1;
      tick();
      bus.mouse_left = 1'b0;
      tick();
      check("rst_pre_hits", bus.hits, 1);
      wait_vis(1'b1, 4);
      tick();
      rst_d = 1'b1;
      tick();
      check_all_zero("midrst");
      rst_d = 1'b0;
      bus.game_active = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
